// File: rtl/fetch_sequencer_if.sv
// Control-decoder / instruction-ROM side bundle of the fetch sequencer.
// The master drives control inputs; the sequencer (slave) returns PC and status.
interface fetch_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int OFF_W = 6
);
    logic             Start;
    logic [PC_W-1:0]  Start_Addr;
    logic             Stall;
    logic             Branch;
    logic [1:0]       Cond;
    logic             Zero;
    logic [1:0]       Mode;
    logic [OFF_W-1:0] Offset;
    logic             Call;
    logic             Ret;
    logic             Halt_In;
    logic [PC_W-1:0]  PC;
    logic             Halted;
    logic             Ras_Empty;
    logic             Ras_Full;
    logic             Ras_Err;

    modport master (
        output Start, Start_Addr, Stall, Branch, Cond, Zero, Mode, Offset,
               Call, Ret, Halt_In,
        input  PC, Halted, Ras_Empty, Ras_Full, Ras_Err
    );

    modport slave (
        input  Start, Start_Addr, Stall, Branch, Cond, Zero, Mode, Offset,
               Call, Ret, Halt_In,
        output PC, Halted, Ras_Empty, Ras_Full, Ras_Err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Next-instruction sequencer: relative/page/absolute branches, conditional
// branching, stall, halt and a return-address stack for call/return.
module fetch_sequencer #(
    parameter int PC_W      = 8,
    parameter int OFF_W     = 6,
    parameter int PAGE_BITS = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    fetch_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];

    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_top;
    logic             w_empty;
    logic             w_full;
    logic             w_taken;
    logic             w_push;

    // Mode 2'b11 is reserved and falls through to relative.
    function automatic logic [PC_W-1:0] f_target(
        input logic [PC_W-1:0]  pc,
        input logic [1:0]       mode,
        input logic [OFF_W-1:0] off
    );
        logic [PC_W-1:0]         page_mask;
        logic signed [OFF_W-1:0] off_s;
        page_mask = {PC_W{1'b1}} << PAGE_BITS;
        off_s     = off;
        case (mode)
            2'b01:   f_target = (pc & page_mask) | (PC_W'(off) & ~page_mask);
            2'b10:   f_target = PC_W'(off);
            default: f_target = pc + PC_W'(off_s);
        endcase
    endfunction

    function automatic logic f_cond(input logic [1:0] cond, input logic zero);
        case (cond)
            2'b00:   f_cond = 1'b1;
            2'b01:   f_cond = !zero;
            2'b10:   f_cond = zero;
            default: f_cond = 1'b0;
        endcase
    endfunction

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_target = f_target(r_pc, bus.Mode, bus.Offset);
    assign w_top    = r_ras[IDX_W'(r_cnt - CNT_W'(1))];
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CNT_W'(RAS_DEPTH));
    assign w_taken  = bus.Branch && f_cond(bus.Cond, bus.Zero);

    // Must mirror exactly the Call branch of the control block below.
    assign w_push = !Reset && !bus.Start && (r_state == S_RUN) && !bus.Halt_In &&
                    !bus.Stall && !bus.Ret && bus.Call && !w_full;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc    <= '0;
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (bus.Start) begin
            r_pc    <= bus.Start_Addr;
            r_state <= S_RUN;
        end else if (r_state == S_RUN) begin
            if (bus.Halt_In) begin
                r_state <= S_HALT;
            end else if (!bus.Stall) begin
                if (bus.Ret) begin
                    if (w_empty) begin
                        r_err <= 1'b1;
                        r_pc  <= w_pc_inc;
                    end else begin
                        r_pc  <= w_top;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end else if (bus.Call) begin
                    if (w_full) r_err <= 1'b1;
                    else        r_cnt <= r_cnt + CNT_W'(1);
                    r_pc <= w_target;
                end else if (w_taken) begin
                    r_pc <= w_target;
                end else begin
                    r_pc <= w_pc_inc;
                end
            end
        end
    end

    // Stack storage is never reset; only the count says which entries are live.
    always_ff @(posedge CLK) begin
        if (w_push) r_ras[IDX_W'(r_cnt)] <= w_pc_inc;
    end

    assign bus.PC        = r_pc;
    assign bus.Halted    = (r_state == S_HALT);
    assign bus.Ras_Empty = w_empty;
    assign bus.Ras_Full  = w_full;
    assign bus.Ras_Err   = r_err;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: queue-based reference model checked every
// cycle, plus hand-computed PC/flag expectations for the directed scenarios.
module tb_fetch_sequencer;
    localparam int PC_W      = 8;
    localparam int OFF_W     = 6;
    localparam int PAGE_BITS = 6;
    localparam int RAS_DEPTH = 4;
    localparam int PC_MOD    = 1 << PC_W;

    logic clk;
    logic rst;

    fetch_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

    fetch_sequencer #(
        .PC_W(PC_W), .OFF_W(OFF_W), .PAGE_BITS(PAGE_BITS), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int m_pc;
    bit m_halted;
    bit m_err;
    bit m_valid = 1'b0;
    int m_stack[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference target arithmetic on plain integers.
    function automatic int m_target(input int pc, input int mode, input int off);
        int soff;
        int pg;
        soff = (off >= (1 << (OFF_W - 1))) ? off - (1 << OFF_W) : off;
        pg   = 1 << PAGE_BITS;
        case (mode)
            1:       return (pc / pg) * pg + (off % pg);
            2:       return off;
            default: return (pc + soff + PC_MOD) % PC_MOD;
        endcase
    endfunction

    function automatic bit m_cond(input int cond, input bit zero);
        case (cond)
            0:       return 1'b1;
            1:       return !zero;
            2:       return zero;
            default: return 1'b0;
        endcase
    endfunction

    // Model advances on each edge, then outputs are compared 1 time unit later.
    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_halted = 0; m_err = 0; m_stack.delete(); m_valid = 1;
        end else if (bus.Start) begin
            m_pc = int'(bus.Start_Addr); m_halted = 0;
        end else if (!m_halted) begin
            if (bus.Halt_In) m_halted = 1;
            else if (bus.Stall) begin
            end else if (bus.Ret) begin
                if (m_stack.size() == 0) begin
                    m_err = 1; m_pc = (m_pc + 1) % PC_MOD;
                end else m_pc = m_stack.pop_back();
            end else if (bus.Call) begin
                if (m_stack.size() == RAS_DEPTH) m_err = 1;
                else m_stack.push_back((m_pc + 1) % PC_MOD);
                m_pc = m_target(m_pc, int'(bus.Mode), int'(bus.Offset));
            end else if (bus.Branch && m_cond(int'(bus.Cond), bus.Zero))
                m_pc = m_target(m_pc, int'(bus.Mode), int'(bus.Offset));
            else m_pc = (m_pc + 1) % PC_MOD;
        end
        #1;
        if (m_valid) begin
            chk("model_pc", bus.PC, m_pc);
            chk("model_halted", bus.Halted, m_halted);
            chk("model_empty", bus.Ras_Empty, m_stack.size() == 0);
            chk("model_full", bus.Ras_Full, m_stack.size() == RAS_DEPTH);
            chk("model_err", bus.Ras_Err, m_err);
        end
    end

    task automatic idle();
        bus.Start = 0; bus.Start_Addr = '0; bus.Stall = 0; bus.Branch = 0;
        bus.Cond = 2'b00; bus.Zero = 0; bus.Mode = 2'b00; bus.Offset = '0;
        bus.Call = 0; bus.Ret = 0; bus.Halt_In = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Hand-computed PC expectation applied to both DUT and model.
    task automatic lit_pc(input string nm, input int exp);
        chk({nm, "_dut"}, bus.PC, exp);
        chk({nm, "_model"}, m_pc, exp);
    endtask

    task automatic start_at(input int addr);
        idle(); bus.Start = 1; bus.Start_Addr = addr[PC_W-1:0];
        step(); idle();
    endtask

    task automatic branch(input int cond, input bit zero, input int mode, input int off);
        idle(); bus.Branch = 1; bus.Cond = cond[1:0]; bus.Zero = zero;
        bus.Mode = mode[1:0]; bus.Offset = off[OFF_W-1:0];
        step(); idle();
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        rst = 0;
        lit_pc("reset_pc", 0);
        chk("reset_halted", bus.Halted, 0);
        chk("reset_empty", bus.Ras_Empty, 1);
        chk("reset_full", bus.Ras_Full, 0);
        chk("reset_err", bus.Ras_Err, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            lit_pc("incr", i);
        end

        start_at(8'hFF);
        lit_pc("start_ff", 8'hFF);
        step();
        lit_pc("wrap", 8'h00);

        start_at(8'h4B);
        branch(1, 0, 1, 6'h05);
        lit_pc("page_taken", 8'h45);
        start_at(8'h4B);
        branch(1, 1, 1, 6'h05);
        lit_pc("page_not_taken", 8'h4C);

        start_at(8'h10);
        branch(0, 0, 0, 6'h3E);
        lit_pc("rel_minus2", 8'h0E);
        start_at(8'h01);
        branch(0, 0, 0, 6'h3C);
        lit_pc("rel_wrap", 8'hFD);
        start_at(8'h10);
        branch(3, 0, 2, 6'h30);
        lit_pc("cond_never", 8'h11);
        branch(2, 1, 3, 6'h02);
        lit_pc("mode_reserved", 8'h13);

        start_at(8'h20);
        for (int i = 1; i <= 5; i++) begin
            idle(); bus.Call = 1; bus.Mode = 2'b10; bus.Offset = 6'h30;
            step();
            lit_pc("call", 8'h30);
            if (i == 4) begin
                chk("full_after_4", bus.Ras_Full, 1);
                chk("err_after_4", bus.Ras_Err, 0);
            end
        end
        chk("err_after_5", bus.Ras_Err, 1);
        idle(); bus.Ret = 1;
        step(); lit_pc("ret1", 8'h31);
        step(); lit_pc("ret2", 8'h31);
        step(); lit_pc("ret3", 8'h31);
        step(); lit_pc("ret4", 8'h21);
        chk("empty_after_rets", bus.Ras_Empty, 1);
        step(); lit_pc("ret_underflow", 8'h22);
        idle();

        start_at(8'h07);
        idle(); bus.Halt_In = 1; bus.Branch = 1; bus.Mode = 2'b10; bus.Offset = 6'h11;
        step();
        for (int i = 0; i < 10; i++) begin
            idle(); bus.Branch = 1; bus.Mode = 2'b10; bus.Offset = 6'h11;
            bus.Call = i[0]; bus.Ret = i[1]; bus.Halt_In = i[2];
            lit_pc("halt_hold", 8'h07);
            chk("halted", bus.Halted, 1);
            step();
        end
        start_at(8'h40);
        lit_pc("resume", 8'h40);
        chk("resumed", bus.Halted, 0);

        for (int i = 0; i < 2; i++) begin
            idle(); bus.Call = 1; bus.Mode = 2'b10; bus.Offset = 6'h10;
            step();
        end
        lit_pc("two_calls", 8'h10);
        for (int i = 0; i < 3; i++) begin
            idle(); bus.Call = 1; bus.Stall = 1; bus.Mode = 2'b10; bus.Offset = 6'h20;
            step();
            lit_pc("stall_hold", 8'h10);
            chk("stall_not_empty", bus.Ras_Empty, 0);
            chk("stall_not_full", bus.Ras_Full, 0);
        end
        rst = 1;
        step();
        rst = 0;
        idle();
        lit_pc("reset_mid_stall", 0);
        chk("reset_mid_empty", bus.Ras_Empty, 1);
        chk("reset_mid_err", bus.Ras_Err, 0);

        start_at(8'h50);
        idle(); bus.Call = 1; bus.Ret = 1; bus.Mode = 2'b10; bus.Offset = 6'h05;
        step(); idle();
        lit_pc("ret_beats_call", 8'h51);
        chk("ret_beats_call_err", bus.Ras_Err, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised next-instruction sequencer. Generalises the fixed 8-bit PC with page-masked branch into a configurable-width PC.
- Supports three branch-target modes, selectable branch condition, stall, halt, and a hardware return-address stack for call/return.
- Sits between the control decoder (Branch/Call/Ret/Mode/Cond) and instruction ROM (PC). The ALU supplies Zero.

Parameters:
- PC_W, 8: program counter width in bits.
- OFF_W, 6: branch offset/target field width; must satisfy OFF_W <= PC_W.
- PAGE_BITS, 6: low PC bits replaced in page mode; must satisfy PAGE_BITS <= PC_W.
- RAS_DEPTH, 4: return-address stack entries; must be >= 1.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  load Start_Addr into PC, clear halt.
- Start_Addr  in  PC_W  program start address.
- Stall  in  1  hold PC and stack this cycle.
- Branch  in  1  branch request, subject to Cond.
- Cond  in  2  branch condition: 00 always, 01 take if !Zero, 10 take if Zero, 11 never.
- Zero  in  1  ALU zero flag.
- Mode  in  2  target mode: 00 relative, 01 page, 10 absolute, 11 reserved (treated as relative).
- Offset  in  OFF_W  offset/target field.
- Call  in  1  push return address, jump unconditionally.
- Ret  in  1  pop return address into PC.
- Halt_In  in  1  enter HALTED.
- PC  out  PC_W  current instruction address.
- Halted  out  1  high in HALTED state.
- Ras_Empty  out  1  stack count == 0.
- Ras_Full  out  1  stack count == RAS_DEPTH.
- Ras_Err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (sync, highest priority): PC=0, state RUN, stack count=0, Ras_Err=0. Stack storage contents are don't-care.
- States are RUN and HALTED.
  - RUN -> HALTED on Halt_In (not Stall-gated). PC is held at its current value.
  - HALTED -> RUN only on Start or Reset. All other inputs are ignored in HALTED.
- Per-cycle priority in RUN: Start > Halt_In > Stall > Ret > Call > taken Branch > increment.
- Start: PC <= Start_Addr; state RUN. Stack count and Ras_Err are preserved. Start in HALTED also resumes.
- Stall: no state change.
- Target computation:
  - Relative: PC + sign-extended Offset, modulo 2^PC_W.
  - Page: {PC[PC_W-1:PAGE_BITS], zero-extended Offset[PAGE_BITS-1:0]}. Offset bits above PAGE_BITS are ignored.
  - Absolute: zero-extended Offset.
- Taken branch: Branch=1 and Cond satisfied -> PC <= target. Otherwise PC <= PC+1, which wraps from 2^PC_W-1 to 0.
- Call: push PC+1 (wrapped), PC <= target per Mode; Cond is ignored.
  - If stack is full: push dropped, Ras_Err <= 1, jump still taken.
- Ret: PC <= top entry, count decrements.
  - If stack is empty: Ras_Err <= 1, PC <= PC+1.
- Call and Ret together: Ret wins, Call ignored.
- Ras_Err clears only on Reset.
- Latency: a control input sampled at edge n is reflected on PC after edge n. PC is a registered output with no combinational path.

Test Plan:
- Reset, then 3 idle cycles -> PC 0,1,2,3. Set PC=8'hFF via Start, idle 1 cycle -> PC=8'h00.
- PC=8'h4B; Branch, Cond=01, Zero=0, Mode=01, Offset=6'h05 -> PC=8'h45. Repeat with Zero=1 -> PC=8'h4C.
- PC=8'h10; Branch, Cond=00, Mode=00, Offset=6'h3E (-2) -> PC=8'h0E. PC=8'h01, Offset=6'h3C (-4) -> PC=8'hFD.
- RAS_DEPTH=4, 5 Calls from PC=8'h20 (Mode=10, Offset=6'h30 each) -> Ras_Full=1 after 4th, Ras_Err=1 after 5th, PC=8'h30. Then 4 Rets -> PCs 8'h31,8'h31,8'h31,8'h21, Ras_Empty=1. 5th Ret -> PC=8'h22.
- Halt_In at PC=8'h07 with Branch asserted -> PC stays 8'h07, Halted=1 for 10 cycles. Start with Start_Addr=8'h40 -> PC=8'h40, Halted=0.
- Stall held 3 cycles during a pending Call -> PC and stack count unchanged. Reset mid-stall with count=2 -> PC=0, Ras_Empty=1, Ras_Err=0.
